// File: rtl/fifo_bus_sel_arbiter.sv
// rtl/fifo_bus_sel_arbiter.sv - Round-robin fd arbiter streaming FWFT FIFO bursts to the granted requester
module fifo_bus_sel_arbiter #(
    parameter int PORT_NUM   = 8,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PORT_NUM-1:0]   bus_sel,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    input  logic [PORT_NUM-1:0]   bus_ready,
    output logic [PORT_NUM-1:0]   bus_grant,
    output logic                  bus_valid,
    output logic [DATA_WIDTH-1:0] bus_data
);

    localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]         grant_idx_q, grant_idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PORT_NUM-1:0]   bus_grant_q, bus_grant_d;
    logic                  bus_valid_q, bus_valid_d;
    logic [DATA_WIDTH-1:0] bus_data_q, bus_data_d;

    logic                  pick_found;
    logic [PW-1:0]         pick_idx;
    logic [PW:0]           cand;
    logic [PW:0]           rr_next;
    logic                  sel_ready;

    assign sel_ready = bus_ready[grant_idx_q];

    // Search upward from rr_ptr, wrapping at PORT_NUM, for the first requester.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            cand = {1'b0, rr_ptr_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(PORT_NUM)) begin
                cand = cand - (PW+1)'(PORT_NUM);
            end
            if (!pick_found && bus_sel[cand[PW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[PW-1:0];
            end
        end
        rr_next = {1'b0, pick_idx} + (PW+1)'(1);
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        cnt_d       = cnt_q;
        bus_grant_d = bus_grant_q;
        bus_valid_d = bus_valid_q;
        bus_data_d  = bus_data_q;
        fifo_rd_en  = 1'b0;

        case (state_q)
            IDLE: begin
                bus_grant_d = '0;
                if (pick_found && !fifo_empty) begin
                    grant_idx_d = pick_idx;
                    rr_ptr_d    = (rr_next == (PW+1)'(PORT_NUM)) ? '0 : rr_next[PW-1:0];
                    bus_grant_d = PORT_NUM'(1) << pick_idx;
                    cnt_d       = '0;
                    state_d     = XFER;
                end
            end
            XFER: begin
                fifo_rd_en = !fifo_empty && bus_sel[grant_idx_q] &&
                             (cnt_q < CW'(BURST_LEN)) && (!bus_valid_q || sel_ready);
                if (fifo_rd_en) begin
                    bus_data_d  = fifo_dout;
                    bus_valid_d = 1'b1;
                    cnt_d       = cnt_q + CW'(1);
                end else if (bus_valid_q && sel_ready) begin
                    bus_valid_d = 1'b0;
                end
                // A withdrawn request ends the burst; any held word still drains.
                if ((fifo_rd_en && cnt_q == CW'(BURST_LEN - 1)) || !bus_sel[grant_idx_q]) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus_valid_q || sel_ready) begin
                    bus_valid_d = 1'b0;
                    bus_grant_d = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            cnt_q       <= '0;
            bus_grant_q <= '0;
            bus_valid_q <= 1'b0;
            bus_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            cnt_q       <= cnt_d;
            bus_grant_q <= bus_grant_d;
            bus_valid_q <= bus_valid_d;
            bus_data_q  <= bus_data_d;
        end
    end

    assign bus_grant = bus_grant_q;
    assign bus_valid = bus_valid_q;
    assign bus_data  = bus_data_q;

endmodule

// File: tb/tb_fifo_bus_sel_arbiter.sv
// tb/tb_fifo_bus_sel_arbiter.sv - Randomized model-checked bench for fifo_bus_sel_arbiter
module tb_fifo_bus_sel_arbiter;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int BL = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  bus_sel;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_en;
    logic [N-1:0]  bus_ready;
    logic [N-1:0]  bus_grant;
    logic          bus_valid;
    logic [DW-1:0] bus_data;

    fifo_bus_sel_arbiter #(.PORT_NUM(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_sel    (bus_sel),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .bus_ready  (bus_ready),
        .bus_grant  (bus_grant),
        .bus_valid  (bus_valid),
        .bus_data   (bus_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [DW-1:0] q[$];
    int            wr_ctr = 0;
    int            next_exp = 0;
    logic          stall = 1'b0;

    // Behavioural model: who owns the bus, how many words it has had, whether it is winding down.
    int            m_owner = -1;
    int            m_rr = 0;
    int            m_words = 0;
    bit            m_ending = 1'b0;
    bit            m_valid = 1'b0;
    logic [DW-1:0] m_data = '0;

    logic [N-1:0]  s_sel, s_rdy;
    logic          s_empty, e_rd, d_rd;
    logic [DW-1:0] s_dout;

    logic [N-1:0]  prev_g = '0;
    int            wpg = 0;
    int            glog[$];
    int            wlog[$];

    function automatic logic [DW-1:0] word(input int n);
        return 32'hC0DE_0000 + DW'(n);
    endfunction

    function automatic int pick(input logic [N-1:0] s, input int rr);
        for (int i = 0; i < N; i++) begin
            if (s[(rr + i) % N]) return (rr + i) % N;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    task automatic model_reset();
        m_owner = -1; m_rr = 0; m_words = 0; m_ending = 1'b0; m_valid = 1'b0; m_data = '0;
        prev_g = '0; wpg = 0;
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            q.push_back(word(wr_ctr));
            wr_ctr++;
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = stall || (q.size() == 0);
        fifo_dout  = (q.size() != 0) ? q[0] : '0;
    endtask

    task automatic compare_cycle();
        logic [N-1:0] eg;
        int           gi;
        eg   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e_rd = (m_owner >= 0) && !m_ending && !fifo_empty && bus_sel[m_owner] &&
               (m_words < BL) && (!m_valid || bus_ready[m_owner]);
        chk("grant", 64'(bus_grant), 64'(eg));
        chk("valid", 64'(bus_valid), 64'(m_valid));
        chk("data", 64'(bus_data), 64'(m_data));
        chk("rd_en", 64'(fifo_rd_en), 64'(e_rd));
        if (bus_valid && ((bus_ready & bus_grant) != '0)) begin
            chk("accept_order", 64'(bus_data), 64'(word(next_exp)));
            next_exp++;
            wpg++;
        end
        if (prev_g == '0 && bus_grant != '0) begin
            gi = 0;
            for (int i = 0; i < N; i++) if (bus_grant[i]) gi = i;
            glog.push_back(gi);
        end
        if (prev_g != '0 && bus_grant == '0) begin
            wlog.push_back(wpg);
            wpg = 0;
        end
        prev_g = bus_grant;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (m_owner < 0) begin
            if (s_sel != '0 && !s_empty) begin
                m_owner  = pick(s_sel, m_rr);
                m_rr     = (m_owner + 1) % N;
                m_words  = 0;
                m_ending = 1'b0;
            end
        end else if (!m_ending) begin
            if (e_rd) begin
                m_data  = s_dout;
                m_valid = 1'b1;
                m_words++;
            end else if (m_valid && s_rdy[m_owner]) begin
                m_valid = 1'b0;
            end
            if ((e_rd && m_words == BL) || !s_sel[m_owner]) m_ending = 1'b1;
        end else if (!m_valid || s_rdy[m_owner]) begin
            m_valid  = 1'b0;
            m_owner  = -1;
            m_ending = 1'b0;
        end
    endtask

    task automatic tick();
        drive_fifo();
        @(negedge clk);
        if (!rst) compare_cycle();
        s_sel = bus_sel; s_rdy = bus_ready; s_empty = fifo_empty; s_dout = fifo_dout;
        d_rd = fifo_rd_en;
        if (rst) e_rd = 1'b0;
        @(posedge clk);
        model_step();
        if (d_rd && q.size() != 0) void'(q.pop_front());
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_sel = '0;
        q.delete();
        tick();
        tick();
        rst = 1'b0;
        next_exp = wr_ctr;
        glog.delete();
        wlog.delete();
    endtask

    initial begin
        bit done;
        rst = 1'b1; bus_sel = '0; bus_ready = '0; fifo_empty = 1'b1; fifo_dout = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_grant", 64'(bus_grant), 64'h0);
        chk("reset_valid", 64'(bus_valid), 64'h0);
        chk("reset_data", 64'(bus_data), 64'h0);
        chk("reset_rd_en", 64'(fifo_rd_en), 64'h0);
        do_reset();

        // Single requester: two bursts of 4 then 2 words.
        push(6);
        bus_ready = '1;
        bus_sel = 8'h04;
        tick();
        chk("t1_grant_after_req", 64'(bus_grant), 64'h04);
        chk("t1_no_valid_yet", 64'(bus_valid), 64'h0);
        tick();
        chk("t1_first_valid", 64'(bus_valid), 64'h1);
        chk("t1_first_word", 64'(bus_data), 64'(word(0)));
        repeat (16) tick();
        bus_sel = '0;
        repeat (4) tick();
        chk("t1_grants", 64'(glog.size()), 64'd2);
        chk("t1_wlog", 64'(wlog.size()), 64'd2);
        if (glog.size() >= 2 && wlog.size() >= 2) begin
            chk("t1_g0", 64'(glog[0]), 64'd2);
            chk("t1_g1", 64'(glog[1]), 64'd2);
            chk("t1_w0", 64'(wlog[0]), 64'd4);
            chk("t1_w1", 64'(wlog[1]), 64'd2);
        end

        // Round-robin over fds 0, 4, 7 with the FIFO always fed.
        do_reset();
        bus_sel = 8'h91;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            if (q.size() < 4) push(4);
            tick();
            done = (glog.size() >= 7);
        end
        chk("rr_done", 64'(done), 64'h1);
        if (done) begin
            chk("rr_g0", 64'(glog[0]), 64'd0);
            chk("rr_g1", 64'(glog[1]), 64'd4);
            chk("rr_g2", 64'(glog[2]), 64'd7);
            chk("rr_g3", 64'(glog[3]), 64'd0);
            chk("rr_g4", 64'(glog[4]), 64'd4);
            chk("rr_g5", 64'(glog[5]), 64'd7);
            for (int i = 0; i < 5; i++) chk("rr_words", 64'(wlog[i]), 64'(BL));
        end

        // Random requests, backpressure, withdrawals and underruns.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0 && q.size() < 16) push($urandom_range(1, 2));
            if ($urandom_range(0, 15) == 0) bus_sel = N'($urandom);
            bus_ready = N'($urandom) | (($urandom_range(0, 2) == 0) ? '0 : bus_grant);
            stall = ($urandom_range(0, 9) == 0);
            tick();
        end
        stall = 1'b0;

        // Asynchronous reset mid-burst with a word held in the output register.
        do_reset();
        push(6);
        bus_sel = 8'hFF;
        bus_ready = '0;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            tick();
            done = bus_valid;
        end
        chk("rst_pre_valid", 64'(bus_valid), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_grant", 64'(bus_grant), 64'h0);
        chk("rst_async_valid", 64'(bus_valid), 64'h0);
        chk("rst_async_rd_en", 64'(fifo_rd_en), 64'h0);
        q.delete();
        push(4);
        next_exp = wr_ctr - 4;
        tick();
        rst = 1'b0;
        bus_ready = '1;
        tick();
        chk("rst_regrant_fd0", 64'(bus_grant), 64'h01);
        repeat (8) tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fifo_bus_sel_arbiter.md
# fifo_bus_sel_arbiter

FIFO-side arbiter for the fd/fifo bus-select fabric. There is one instance per output FIFO. Its `bus_sel` input is that FIFO's transposed request vector: bit x is driven by fd_x. The block picks one requesting fd round-robin, grants it the bus, and streams up to BURST_LEN words from a first-word-fall-through FIFO through a registered valid/ready output stage. It releases the grant when the burst completes or the requester withdraws.

## Interface
- PORT_NUM, 8, number of fd requesters; must be ≥2
- DATA_WIDTH, 32, FIFO word width
- BURST_LEN, 16, maximum words per grant; must be ≥1
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- bus_sel  in  PORT_NUM  request vector; bit x = request from fd_x
- fifo_empty  in  1  FWFT FIFO empty flag
- fifo_dout  in  DATA_WIDTH  FWFT head word; valid when !fifo_empty
- fifo_rd_en  out  1  pop head word (combinational)
- bus_ready  in  PORT_NUM  per-fd ready; only bit grant_idx is used
- bus_grant  out  PORT_NUM  one-hot grant, registered
- bus_valid  out  1  output word valid, registered
- bus_data  out  DATA_WIDTH  output word, registered

## Operation
- Internal registers:
  - state ∈ {IDLE, XFER, DRAIN}
  - rr_ptr, clog2(PORT_NUM) bits
  - grant_idx
  - cnt, clog2(BURST_LEN+1) bits
- Reset values: state=IDLE, rr_ptr=0, grant_idx=0, cnt=0, bus_grant=0, bus_valid=0, bus_data=0. fifo_rd_en=0 whenever state≠XFER.
- sel_ready = bus_ready[grant_idx].
- IDLE:
  - bus_grant=0.
  - If |bus_sel && !fifo_empty: grant_idx ← first set bit of bus_sel searching upward from rr_ptr, wrapping at PORT_NUM.
  - In the same edge: rr_ptr ← (grant_idx+1) mod PORT_NUM, bus_grant ← one-hot(grant_idx), cnt ← 0, state ← XFER.
  - Otherwise stay in IDLE.
- XFER:
  - fifo_rd_en = !fifo_empty && bus_sel[grant_idx] && cnt<BURST_LEN && (!bus_valid || sel_ready).
  - On fifo_rd_en: bus_data ← fifo_dout, bus_valid ← 1, cnt ← cnt+1.
  - Otherwise, if bus_valid && sel_ready: bus_valid ← 0.
  - Exit to DRAIN when a pop makes cnt reach BURST_LEN, or when bus_sel[grant_idx]=0 (sampled that cycle).
- DRAIN:
  - No pops.
  - Once bus_valid=0, or bus_valid && sel_ready: bus_valid ← 0, bus_grant ← 0, state ← IDLE.
- Requester drop mid-burst: a word already in the output register is held until accepted. bus_grant stays asserted until then.
- FIFO empty mid-burst: remain in XFER with bus_valid low after the last word drains. There is no timeout.
- Requests from other fds during a burst are ignored. They are arbitrated only in IDLE.
- Ready on non-granted bits has no effect.

## Timing
- Request sampled at edge N in IDLE → bus_grant one-hot and state=XFER after edge N.
- fifo_rd_en may assert in cycle N+1; first bus_valid appears after edge N+1.
- Latency from request to first valid word: 2 cycles.
- Throughput: 1 word/cycle while sel_ready=1 and the FIFO is non-empty.
- Transfer occurs at an edge with bus_valid && sel_ready. bus_data is stable while bus_valid && !sel_ready.
- Burst end: the last pop is at edge M; DRAIN holds until the word is accepted. bus_grant falls at the acceptance edge. Earliest re-arbitration in IDLE is the following edge.
- Minimum gap between grants: 1 IDLE cycle with bus_grant=0.
- Reset asserted mid-burst: all registers take reset values immediately (asynchronous). An in-flight word is discarded. Deassertion is synchronous to clk.

## Test plan
- Single requester, PORT_NUM=8, BURST_LEN=4, FIFO holds 6 words, ready=1. bus_sel=8'h04 → bus_grant=8'h04 one cycle after request; words 0–3 appear on consecutive cycles; grant drops. After 1 IDLE cycle, grant 8'h04 again; words 4–5 follow.
- Round-robin fairness, bus_sel=8'h91 held, FIFO always non-empty. Grant order is 0, 4, 7, 0, 4, 7; each grant carries exactly BURST_LEN words.
- Backpressure: ready toggles 1,0,0,1 during a burst. bus_data is held constant while ready=0. No FIFO pop while the output register is full and ready=0. cnt reaches BURST_LEN with no word lost or duplicated.
- Requester drop: fd_2 deasserts bus_sel after 2 accepted words, with 1 word pending and ready=0. No further pops. Grant holds until the pending word is accepted, then bus_grant=0.
- FIFO underrun: FIFO empties after word 1 of a 4-word burst. bus_valid goes low, grant is held. Refilling the FIFO resumes delivery of words 2–3.
- Async reset asserted mid-burst with bus_valid=1. Same cycle: bus_grant=0, bus_valid=0, fifo_rd_en=0. After release, rr_ptr=0, so bus_sel=8'hFF grants fd_0 first.
